// File: rtl/axilite_cfg_pkg.sv
// Shared types and constants for the AXI-Lite to threshold-core config bridge.
package axilite_cfg_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RD_WAIT = 2'b01,
        B_RESP  = 2'b10,
        R_RESP  = 2'b11
    } state_e;

    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry AXI channel holding register: accepts a beat when empty, keeps it
// until the bridge issues the transaction that consumes it.
module axil_hold_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_held,
    output logic [W-1:0] o_data,
    input  logic         i_free
);

    logic         r_held;
    logic [W-1:0] r_data;

    assign o_ready = !r_held && !rst;
    assign o_held  = r_held;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held <= 1'b0;
            r_data <= '0;
        end else if (i_free) begin
            r_held <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_held <= 1'b1;
            r_data <= i_data;
        end
    end

endmodule

// File: rtl/axilite_cfg_bridge.sv
// AXI-Lite slave bridging host register accesses onto the thresholding core's
// single-cycle cfg port, one transaction at a time, with a bounded readback wait.
module axilite_cfg_bridge
    import axilite_cfg_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int CFG_A_BITS = 8,
    parameter int K          = 16,
    parameter int SIGN_EXT   = 1,
    parameter int RD_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_BITS-1:0]  s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_BITS-1:0]  s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  cfg_en,
    output logic                  cfg_we,
    output logic [CFG_A_BITS-1:0] cfg_a,
    output logic [K-1:0]          cfg_d,
    input  logic                  cfg_rack,
    input  logic [K-1:0]          cfg_q
);

    localparam int IDX_W = ADDR_BITS - WORD_SHIFT;
    localparam int CNT_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;

    logic                 w_aw_held, w_w_held, w_ar_held;
    logic [ADDR_BITS-1:0] w_aw_addr, w_ar_addr;
    logic [K-1:0]         w_wdata;
    logic [IDX_W-1:0]     w_aw_idx, w_ar_idx;
    logic                 w_aw_ok, w_ar_ok;
    logic                 w_do_wr, w_do_rd;
    logic [31:0]          w_rack_ext;
    logic                 w_unused;

    state_e               r_state;
    logic                 r_wr_prio;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_bvalid, r_rvalid;
    resp_e                r_bresp, r_rresp;
    logic [31:0]          r_rdata;

    axil_hold_reg #(.W(ADDR_BITS)) u_aw (
        .clk(clk), .rst(rst), .i_valid(s_awvalid), .o_ready(s_awready),
        .i_data(s_awaddr), .o_held(w_aw_held), .o_data(w_aw_addr), .i_free(w_do_wr)
    );

    axil_hold_reg #(.W(K)) u_w (
        .clk(clk), .rst(rst), .i_valid(s_wvalid), .o_ready(s_wready),
        .i_data(s_wdata[K-1:0]), .o_held(w_w_held), .o_data(w_wdata), .i_free(w_do_wr)
    );

    axil_hold_reg #(.W(ADDR_BITS)) u_ar (
        .clk(clk), .rst(rst), .i_valid(s_arvalid), .o_ready(s_arready),
        .i_data(s_araddr), .o_held(w_ar_held), .o_data(w_ar_addr), .i_free(w_do_rd)
    );

    assign w_aw_idx = w_aw_addr[ADDR_BITS-1:WORD_SHIFT];
    assign w_ar_idx = w_ar_addr[ADDR_BITS-1:WORD_SHIFT];
    assign w_aw_ok  = (w_aw_idx >> CFG_A_BITS) == '0;
    assign w_ar_ok  = (w_ar_idx >> CFG_A_BITS) == '0;

    // Issue straight out of the holding registers so cfg_en lands the cycle
    // after the last handshake; round-robin only matters when both are ready.
    assign w_do_wr = !rst && (r_state == IDLE) && w_aw_held && w_w_held
                     && (!w_ar_held || r_wr_prio);
    assign w_do_rd = !rst && (r_state == IDLE) && w_ar_held && !w_do_wr;

    assign cfg_en = (w_do_wr && w_aw_ok) || (w_do_rd && w_ar_ok);
    assign cfg_we = w_do_wr && w_aw_ok;
    assign cfg_a  = (w_do_wr && w_aw_ok) ? w_aw_idx[CFG_A_BITS-1:0] :
                    (w_do_rd && w_ar_ok) ? w_ar_idx[CFG_A_BITS-1:0] : '0;
    assign cfg_d  = (w_do_wr && w_aw_ok) ? w_wdata : '0;

    for (genvar gi = 0; gi < 32; gi++) begin : g_ext
        if (gi < K) begin : g_data
            assign w_rack_ext[gi] = cfg_q[gi];
        end else begin : g_fill
            assign w_rack_ext[gi] = (SIGN_EXT != 0) ? cfg_q[K-1] : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_prio <= 1'b1;
            r_cnt     <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
            r_rvalid  <= 1'b0;
            r_rresp   <= OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_do_wr) begin
                        r_wr_prio <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_aw_ok ? OKAY : SLVERR;
                        r_state   <= B_RESP;
                    end else if (w_do_rd) begin
                        r_wr_prio <= 1'b1;
                        if (w_ar_ok) begin
                            r_cnt   <= '0;
                            r_state <= RD_WAIT;
                        end else begin
                            r_rvalid <= 1'b1;
                            r_rresp  <= SLVERR;
                            r_rdata  <= '0;
                            r_state  <= R_RESP;
                        end
                    end
                end
                RD_WAIT: begin
                    // Rack is checked first so it wins on the expiry cycle.
                    if (cfg_rack) begin
                        r_rvalid <= 1'b1;
                        r_rresp  <= OKAY;
                        r_rdata  <= w_rack_ext;
                        r_state  <= R_RESP;
                    end else if (r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        r_rvalid <= 1'b1;
                        r_rresp  <= SLVERR;
                        r_rdata  <= '0;
                        r_state  <= R_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                B_RESP: begin
                    if (s_bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                R_RESP: begin
                    if (s_rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_bvalid = r_bvalid;
    assign s_bresp  = r_bresp;
    assign s_rvalid = r_rvalid;
    assign s_rresp  = r_rresp;
    assign s_rdata  = r_rdata;

    assign w_unused = &{1'b0, s_wstrb, s_wdata, w_aw_addr[WORD_SHIFT-1:0],
                        w_ar_addr[WORD_SHIFT-1:0]};

endmodule

// File: tb/tb_axilite_cfg_bridge.sv
// Directed bench for axilite_cfg_bridge: queue-based scoreboard on the cfg port
// and AXI responses, plus cycle-exact literal checks; a zero-extend twin checks rdata.
module tb_axilite_cfg_bridge;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, wvalid, arvalid, bready, rready, cfg_rack;
    logic [15:0] awaddr, araddr, cfg_q;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        awready, wready, arready, bvalid, rvalid, cfg_en, cfg_we;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  cfg_a;
    logic [15:0] cfg_d;

    logic        awready1, wready1, arready1, bvalid1, rvalid1, cfg_en1, cfg_we1;
    logic [1:0]  bresp1, rresp1;
    logic [31:0] rdata1;
    logic [7:0]  cfg_a1;
    logic [15:0] cfg_d1;

    always #5 clk = ~clk;

    axilite_cfg_bridge #(.ADDR_BITS(16), .CFG_A_BITS(8), .K(16), .SIGN_EXT(1), .RD_TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst(rst),
        .s_awvalid(awvalid), .s_awready(awready), .s_awaddr(awaddr),
        .s_wvalid(wvalid), .s_wready(wready), .s_wdata(wdata), .s_wstrb(wstrb),
        .s_bvalid(bvalid), .s_bready(bready), .s_bresp(bresp),
        .s_arvalid(arvalid), .s_arready(arready), .s_araddr(araddr),
        .s_rvalid(rvalid), .s_rready(rready), .s_rdata(rdata), .s_rresp(rresp),
        .cfg_en(cfg_en), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_d(cfg_d),
        .cfg_rack(cfg_rack), .cfg_q(cfg_q)
    );

    axilite_cfg_bridge #(.ADDR_BITS(16), .CFG_A_BITS(8), .K(16), .SIGN_EXT(0), .RD_TIMEOUT(TMO)) u_zext (
        .clk(clk), .rst(rst),
        .s_awvalid(awvalid), .s_awready(awready1), .s_awaddr(awaddr),
        .s_wvalid(wvalid), .s_wready(wready1), .s_wdata(wdata), .s_wstrb(wstrb),
        .s_bvalid(bvalid1), .s_bready(bready), .s_bresp(bresp1),
        .s_arvalid(arvalid), .s_arready(arready1), .s_araddr(araddr),
        .s_rvalid(rvalid1), .s_rready(rready), .s_rdata(rdata1), .s_rresp(rresp1),
        .cfg_en(cfg_en1), .cfg_we(cfg_we1), .cfg_a(cfg_a1), .cfg_d(cfg_d1),
        .cfg_rack(cfg_rack), .cfg_q(cfg_q)
    );

    typedef struct {logic we; logic [7:0] a; logic [15:0] d;} cfg_t;
    typedef struct {logic [1:0] resp; logic [31:0] d_sx; logic [31:0] d_zx;} rsp_t;

    cfg_t        exp_cfg[$];
    logic [1:0]  exp_b[$];
    rsp_t        exp_r[$];

    int total = 0;
    int bad   = 0;
    int en_cnt = 0;
    int rack_dly = 0;
    logic [15:0] q_val = '0;
    logic stray_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [15:0] d);
        cfg_t c;
        c.we = 1'b1; c.a = a; c.d = d;
        exp_cfg.push_back(c);
        exp_b.push_back(2'b00);
    endtask

    task automatic push_rd_issue(input logic [7:0] a);
        cfg_t c;
        c.we = 1'b0; c.a = a; c.d = '0;
        exp_cfg.push_back(c);
    endtask

    task automatic push_rsp_ok(input logic [15:0] q);
        rsp_t r;
        r.resp = 2'b00;
        r.d_sx = {{16{q[15]}}, q};
        r.d_zx = {16'h0000, q};
        exp_r.push_back(r);
    endtask

    task automatic push_rsp_err();
        rsp_t r;
        r.resp = 2'b10; r.d_sx = '0; r.d_zx = '0;
        exp_r.push_back(r);
    endtask

    // Core model: acknowledges each readback rack_dly cycles after cfg_en (0 = never).
    int rk_cnt = 0;
    initial forever begin
        @(negedge clk);
        cfg_rack = 1'b0;
        cfg_q    = '0;
        if (rk_cnt > 0) begin
            rk_cnt--;
            if (rk_cnt == 0) begin
                cfg_rack = 1'b1;
                cfg_q    = q_val;
            end
        end
        if (stray_req) begin
            cfg_rack  = 1'b1;
            cfg_q     = 16'h5555;
            stray_req = 1'b0;
        end
        if (!rst && cfg_en && !cfg_we && rack_dly > 0) rk_cnt = rack_dly;
    end

    // Scoreboard: every cfg_en and every response handshake is matched in order.
    logic prev_en = 1'b0;
    logic hs_seen = 1'b1;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_en = 1'b0;
            hs_seen = 1'b1;
        end else begin
            if (cfg_en) begin
                cfg_t e;
                en_cnt++;
                chk("cfg_en_back_to_back", prev_en, 1'b0);
                chk("cfg_en_without_handshake_between", hs_seen, 1'b1);
                hs_seen = 1'b0;
                if (exp_cfg.size() == 0) begin
                    chk("cfg_en_unexpected", cfg_en, 1'b0);
                end else begin
                    e = exp_cfg.pop_front();
                    chk("cfg_we", cfg_we, e.we);
                    chk("cfg_a", cfg_a, e.a);
                    chk("cfg_d", cfg_d, e.d);
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) chk("bvalid_unexpected", bvalid, 1'b0);
                else if (bready) begin
                    chk("bresp", bresp, exp_b.pop_front());
                    hs_seen = 1'b1;
                end
            end
            if (rvalid) begin
                if (exp_r.size() == 0) chk("rvalid_unexpected", rvalid, 1'b0);
                else if (rready) begin
                    rsp_t r;
                    r = exp_r.pop_front();
                    chk("rresp", rresp, r.resp);
                    chk("rdata_sext", rdata, r.d_sx);
                    chk("rdata_zext", rdata1, r.d_zx);
                    hs_seen = 1'b1;
                end
            end
            prev_en = cfg_en;
        end
    end

    task automatic send_aw(input logic [15:0] a);
        int n = 0;
        awaddr = a; awvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!awready && n < 300);
        if (!awready) chk("awready_wait", awready, 1'b1);
        step();
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d);
        int n = 0;
        wdata = d; wvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!wready && n < 300);
        if (!wready) chk("wready_wait", wready, 1'b1);
        step();
        wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] a);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        do begin @(negedge clk); n++; end while (!arready && n < 300);
        if (!arready) chk("arready_wait", arready, 1'b1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((exp_cfg.size() + exp_b.size() + exp_r.size()) != 0 && n < maxc) begin
            step();
            n++;
        end
        chk("drain_left", exp_cfg.size() + exp_b.size() + exp_r.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int en0;
        int n;
        rst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = 4'hF;
        repeat (3) step();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);
        chk("post_rst_valids", {bvalid, rvalid, cfg_en, cfg_we}, 4'b0000);
        chk("post_rst_resps", {bresp, rresp}, 4'b0000);
        chk("post_rst_rdata", rdata, 32'h0);

        // W first, AW three cycles later.
        push_wr(8'h04, 16'h1234);
        wdata = 32'h0000_1234; wvalid = 1'b1;
        chk("t1_wready", wready, 1'b1);
        step(); wvalid = 1'b0;
        chk("t1_no_early_en", cfg_en, 1'b0);
        step(); step();
        awaddr = 16'h0010; awvalid = 1'b1;
        step(); awvalid = 1'b0;
        chk("t1_c4_en_we", {cfg_en, cfg_we}, 2'b11);
        chk("t1_c4_a", cfg_a, 8'h04);
        chk("t1_c4_d", cfg_d, 16'h1234);
        chk("t1_c4_bvalid", bvalid, 1'b0);
        step();
        chk("t1_c5_bvalid", bvalid, 1'b1);
        chk("t1_c5_bresp", bresp, 2'b00);
        chk("t1_c5_en", cfg_en, 1'b0);
        step();
        chk("t1_b_done", bvalid, 1'b0);

        // Read with rack 5 cycles after cfg_en.
        rack_dly = 5; q_val = 16'hFF80;
        push_rd_issue(8'h02); push_rsp_ok(16'hFF80);
        araddr = 16'h0008; arvalid = 1'b1;
        step(); arvalid = 1'b0;
        chk("t2_c1_en", {cfg_en, cfg_we}, 2'b10);
        chk("t2_c1_a", cfg_a, 8'h02);
        chk("t2_c1_d", cfg_d, 16'h0000);
        for (int c = 2; c <= 6; c++) begin
            step();
            chk("t2_rvalid_early", rvalid, 1'b0);
        end
        step();
        chk("t2_c7_rvalid", rvalid, 1'b1);
        chk("t2_rdata_sext", rdata, 32'hFFFF_FF80);
        chk("t2_rdata_zext", rdata1, 32'h0000_FF80);
        chk("t2_rresp", rresp, 2'b00);
        step();

        // Out-of-range write and read.
        exp_b.push_back(2'b10); push_rsp_err();
        en0 = en_cnt;
        fork
            send_aw(16'h0400);
            send_w(32'h0000_BEEF);
            send_ar(16'h0400);
        join
        drain(60);
        chk("t3_no_cfg_en", en_cnt - en0, 0);

        // Write and read pending together twice: W, R, W, R.
        do_reset();
        rack_dly = 2; q_val = 16'h8001;
        push_wr(8'h01, 16'h000A); push_rd_issue(8'h02); push_rsp_ok(16'h8001);
        push_wr(8'h03, 16'h000C); push_rd_issue(8'h05); push_rsp_ok(16'h8001);
        fork
            begin send_aw(16'h0004); send_aw(16'h000C); end
            begin send_w(32'h0000_000A); send_w(32'h0000_000C); end
            begin send_ar(16'h0008); send_ar(16'h0014); end
        join
        drain(200);

        // Timeout, then a stray rack that must be ignored.
        rack_dly = 0;
        push_rd_issue(8'h07); push_rsp_err();
        araddr = 16'h001C; arvalid = 1'b1;
        step(); arvalid = 1'b0;
        chk("t5_c1_en", cfg_en, 1'b1);
        for (int c = 2; c <= TMO + 1; c++) begin
            step();
            chk("t5_rvalid_before_tmo", rvalid, 1'b0);
        end
        step();
        chk("t5_tmo_rvalid", rvalid, 1'b1);
        chk("t5_tmo_rresp", rresp, 2'b10);
        chk("t5_tmo_rdata", rdata, 32'h0);
        step(); step(); step();
        stray_req = 1'b1;
        repeat (5) begin
            step();
            chk("t5_stray_rvalid", rvalid, 1'b0);
        end

        // Rack arriving on the expiry cycle wins.
        rack_dly = TMO; q_val = 16'h7FFF;
        push_rd_issue(8'h07); push_rsp_ok(16'h7FFF);
        araddr = 16'h001C; arvalid = 1'b1;
        step(); arvalid = 1'b0;
        for (int c = 2; c <= TMO + 1; c++) begin
            step();
            chk("t5b_rvalid_early", rvalid, 1'b0);
        end
        step();
        chk("t5b_rvalid", rvalid, 1'b1);
        chk("t5b_rresp", rresp, 2'b00);
        chk("t5b_rdata", rdata, 32'h0000_7FFF);
        step();

        // Back-pressure on R, a queued AR, then reset mid RD_WAIT.
        rready = 1'b0; rack_dly = 1; q_val = 16'h0042;
        push_rd_issue(8'h03); push_rsp_ok(16'h0042);
        send_ar(16'h000C);
        n = 0;
        while (!rvalid && n < 20) begin step(); n++; end
        chk("t6_rvalid_wait", rvalid, 1'b1);
        en0 = en_cnt;
        araddr = 16'h0010; arvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!arready) arvalid = 1'b0;
            chk("t6_hold_rvalid", rvalid, 1'b1);
            chk("t6_hold_rdata", rdata, 32'h0000_0042);
            chk("t6_hold_rresp", rresp, 2'b00);
        end
        chk("t6_ar2_captured", arready, 1'b0);
        chk("t6_ar2_not_issued", en_cnt - en0, 0);
        rack_dly = 0;
        push_rd_issue(8'h04);
        rready = 1'b1;
        n = 0;
        while (en_cnt == en0 && n < 10) begin step(); n++; end
        chk("t6_ar2_issued", en_cnt - en0, 1);
        step(); step(); step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < TMO + 5; c++) begin
            step();
            chk("t6_post_rst_quiet", {rvalid, bvalid, cfg_en}, 3'b000);
        end
        chk("t6_queues_empty", exp_cfg.size() + exp_b.size() + exp_r.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
